fl_fifo_sf: RTL

Parametrised FrameLink FIFO with an integrated control and status unit, successor to the fixed FrameLink FIFO control interface. It buffers single-part FrameLink frames in a register-array memory and can run in cut-through or store-and-forward mode. In store-and-forward mode it can also discard a frame on request from the writer. It sits between a FrameLink producer (RX) and consumer (TX) and exports the standard control set (LSTBLK, STATUS, EMPTY, FULL, FRAME_RDY) plus an exact frame count.

---
 rtl/fl_fifo_sf.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fl_fifo_sf.sv
// FrameLink FIFO with cut-through or store-and-forward release, writer-side
// frame discard, and registered control/status outputs.
module fl_fifo_sf #(
  parameter int DATA_WIDTH        = 32,
  parameter int ITEMS             = 16,
  parameter int STORE_AND_FORWARD = 0,
  parameter int BLOCK_SIZE        = 4,
  parameter int STATUS_WIDTH      = 3,
  localparam int REM_WIDTH        = $clog2(DATA_WIDTH / 8),
  localparam int K                = $clog2(ITEMS)
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [DATA_WIDTH-1:0]   RX_DATA,
  input  logic [REM_WIDTH-1:0]    RX_REM,
  input  logic                    RX_SOF_N,
  input  logic                    RX_EOF_N,
  input  logic                    RX_SRC_RDY_N,
  output logic                    RX_DST_RDY_N,
  input  logic                    RX_DISCARD,
  output logic [DATA_WIDTH-1:0]   TX_DATA,
  output logic [REM_WIDTH-1:0]    TX_REM,
  output logic                    TX_SOF_N,
  output logic                    TX_EOF_N,
  output logic                    TX_SRC_RDY_N,
  input  logic                    TX_DST_RDY_N,
  output logic                    LSTBLK,
  output logic [STATUS_WIDTH-1:0] STATUS,
  output logic                    EMPTY,
  output logic                    FULL,
  output logic                    FRAME_RDY,
  output logic [K:0]              FRAME_CNT
);

  localparam int W = DATA_WIDTH + REM_WIDTH + 2;
  localparam logic [K:0] DEPTH = (K+1)'(ITEMS);
  localparam logic [K:0] BLK = (K+1)'(BLOCK_SIZE);
  localparam logic SAF = (STORE_AND_FORWARD != 0);
  localparam logic [STATUS_WIDTH-1:0] STATUS_RST = DEPTH[K -: STATUS_WIDTH];

  logic [W-1:0]            mem_q [ITEMS];
  logic [K-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [K-1:0]            wr_start_q, wr_start_d;
  logic [K:0]              occ_q, occ_d, free_d, fcnt_q, fcnt_d, drop_cnt;
  logic                    rx_dst_rdy_n_q, tx_vld_q, tx_vld_d;
  logic                    empty_q, full_q, lstblk_q, frame_rdy_q;
  logic [STATUS_WIDTH-1:0] status_q;
  logic [DATA_WIDTH-1:0]   tx_data_q;
  logic [REM_WIDTH-1:0]    tx_rem_q;
  logic                    tx_sof_n_q, tx_eof_n_q;
  logic                    wr_acc, rd_acc, eof_acc, discard, store, commit, rd_eof;
  logic [W-1:0]            wr_word, nxt_word;

  assign wr_acc  = ~RX_SRC_RDY_N & ~rx_dst_rdy_n_q;
  assign rd_acc  = tx_vld_q & ~TX_DST_RDY_N;
  assign eof_acc = wr_acc & ~RX_EOF_N;
  assign discard = SAF & eof_acc & RX_DISCARD;
  assign store   = wr_acc & ~discard;
  assign commit  = eof_acc & ~discard;
  assign rd_eof  = rd_acc & ~tx_eof_n_q;
  assign wr_word = {RX_SOF_N, RX_EOF_N, RX_REM, RX_DATA};

  always_comb begin
    wr_start_d = (wr_acc & ~RX_SOF_N) ? wr_ptr_q : wr_start_q;
    // Words of the current frame already in memory; the discarded EOF itself is never stored.
    drop_cnt   = {1'b0, wr_ptr_q - wr_start_d};
    wr_ptr_d   = wr_ptr_q;
    if (discard)
      wr_ptr_d = wr_start_d;
    else if (store)
      wr_ptr_d = wr_ptr_q + 1'b1;
    rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
    occ_d    = occ_q + (K+1)'(store) - (K+1)'(rd_acc) - (discard ? drop_cnt : '0);
    fcnt_d   = fcnt_q + (K+1)'(commit) - (K+1)'(rd_eof);
    free_d   = DEPTH - occ_d;
    // Only the newest frame can be uncommitted, so any committed frame is the one at the read pointer.
    tx_vld_d = SAF ? (fcnt_d != '0) : (occ_d != '0);
    // A word written this edge into the slot the reader moves to has to bypass memory.
    nxt_word = (store && (wr_ptr_q == rd_ptr_d)) ? wr_word : mem_q[rd_ptr_d];
  end

  always_ff @(posedge CLK) begin
    if (store)
      mem_q[wr_ptr_q] <= wr_word;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      wr_start_q     <= '0;
      occ_q          <= '0;
      fcnt_q         <= '0;
      rx_dst_rdy_n_q <= 1'b1;
      tx_vld_q       <= 1'b0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      lstblk_q       <= 1'b0;
      frame_rdy_q    <= 1'b0;
      status_q       <= STATUS_RST;
      tx_data_q      <= '0;
      tx_rem_q       <= '0;
      tx_sof_n_q     <= 1'b1;
      tx_eof_n_q     <= 1'b1;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_start_q     <= wr_start_d;
      occ_q          <= occ_d;
      fcnt_q         <= fcnt_d;
      rx_dst_rdy_n_q <= (occ_d == DEPTH);
      tx_vld_q       <= tx_vld_d;
      empty_q        <= (occ_d == '0);
      full_q         <= (occ_d == DEPTH);
      lstblk_q       <= (free_d <= BLK);
      frame_rdy_q    <= (fcnt_d != '0);
      status_q       <= free_d[K -: STATUS_WIDTH];
      if (tx_vld_d) begin
        {tx_sof_n_q, tx_eof_n_q, tx_rem_q, tx_data_q} <= nxt_word;
      end else begin
        tx_data_q  <= '0;
        tx_rem_q   <= '0;
        tx_sof_n_q <= 1'b1;
        tx_eof_n_q <= 1'b1;
      end
    end
  end

  assign RX_DST_RDY_N = rx_dst_rdy_n_q;
  assign TX_DATA      = tx_data_q;
  assign TX_REM       = tx_rem_q;
  assign TX_SOF_N     = tx_sof_n_q;
  assign TX_EOF_N     = tx_eof_n_q;
  assign TX_SRC_RDY_N = ~tx_vld_q;
  assign LSTBLK       = lstblk_q;
  assign STATUS       = status_q;
  assign EMPTY        = empty_q;
  assign FULL         = full_q;
  assign FRAME_RDY    = frame_rdy_q;
  assign FRAME_CNT    = fcnt_q;

endmodule
